text_buffer: RTL and testbench
==============================

# text_buffer

Parametrised character text buffer: COLS×ROWS cells of DW-bit character codes (code indexes the character ROM). Sits between the keyboard/terminal write logic and the VGA display fetch path. Adds over the fixed 80×32 buffer a logical-to-physical row mapping for hardware scroll, a one-cell-per-cycle fill engine for clear-screen and scroll-line-clear, and range-checked write rejection.

## Interface
- COLS, 80, columns per row (≥2)
- ROWS, 32, rows (power of two not required, ≥2)
- DW, 8, character code width
- FILL, 8'h20, code written by clear/scroll fill
- localparams: CW = clog2(COLS), RW = clog2(ROWS), DEPTH = COLS*ROWS

- clk  in  1  single clock, all logic on posedge
- resetn  in  1  synchronous, active-low reset
- wr_en  in  1  write strobe (terminal side)
- wr_col  in  CW  logical column
- wr_row  in  RW  logical row
- wr_data  in  DW  character code
- wr_ready  out  1  = ~busy; writes accepted only when high
- rd_en  in  1  read strobe (display side)
- rd_col  in  CW  logical column
- rd_row  in  RW  logical row
- rd_data  out  DW  registered read data
- clear_req  in  1  one-cycle pulse: fill whole buffer, top_row←0
- scroll_req  in  1  one-cycle pulse: scroll up one row, fill new bottom row
- busy  out  1  fill engine active
- top_row  out  RW  physical row currently shown as logical row 0

## Operation
- Mapping: prow = (row + top_row) mod ROWS (compare-and-subtract, no divider); address = prow*COLS + col. Applies to both ports.
- States: IDLE, CLEAR, SCROLL. Fill counter fcnt (clog2(DEPTH) bits).
- IDLE, clear_req=1: top_row←0, fcnt←0, →CLEAR. clear_req wins over simultaneous scroll_req.
- IDLE, scroll_req=1 (clear_req=0): top_row←(top_row+1) mod ROWS (wraps ROWS-1→0), fcnt←0, →SCROLL.
- CLEAR: each cycle memory[fcnt]←FILL, fcnt++; after writing DEPTH-1 →IDLE.
- SCROLL: each cycle writes FILL to physical row (new top_row + ROWS-1) mod ROWS, column fcnt; after column COLS-1 →IDLE.
- Requests arriving in CLEAR/SCROLL are dropped (not queued).
- Write: performed when wr_en & ~busy & wr_col<COLS & wr_row<ROWS; otherwise silently dropped. Write in the same IDLE cycle as an accepted request completes, mapped with the pre-update top_row.
- Read: served every cycle incl. while busy (returns current contents, fill may be partial). Out-of-range rd_col/rd_row returns FILL.
- Same-address read and write in one cycle: read-first (old data).
- Reset (resetn=0 at posedge): state IDLE, busy 0, top_row 0, rd_data 0, fcnt 0; aborts any fill mid-operation. Memory contents are not initialised by reset.

## Timing
- Read latency 1: rd_en at edge N → rd_data valid after edge N, held until next rd_en edge.
- Write latency 1: visible to a read issued at edge N+1.
- busy registered: request accepted at edge N → busy=1 after N; CLEAR writes at edges N+1..N+DEPTH, busy=0 after edge N+DEPTH (DEPTH=2560 default); SCROLL writes at N+1..N+COLS, busy=0 after N+COLS.
- wr_ready combinational from busy only.
- top_row updates after the accepting edge N.

## Configuration
- TEXT_BUFFER_SCROLL_EN defined: scroll logic, top_row register and row-offset adders present as above.
- Not defined: scroll_req ignored, SCROLL state absent, top_row tied 0, prow = row directly; clear, read, write unchanged.

## Test plan
- Reset, clear_req pulse → busy high exactly 2560 cycles; reads of (0,0),(79,31) return 8'h20; top_row=0.
- Write 8'h41 at (5,3), rd_en next cycle → rd_data=8'h41 one cycle later; write at col 80 or row 32 → no memory change.
- Write 'A' to row 1 col 0, scroll_req → top_row=1, busy 80 cycles; logical (0,0) reads 'A', logical row 31 reads all 8'h20; 32 scrolls → top_row wraps to 0.
- wr_en during busy and scroll_req during CLEAR → both dropped, wr_ready=0, contents after clear all FILL.
- clear_req and scroll_req same cycle → CLEAR taken, busy 2560 cycles, top_row 0.
- resetn low midway through CLEAR → busy 0, top_row 0, rd_data 0 next cycle; subsequent write/read works.

Source files
------------

// File: rtl/text_buffer.sv
// COLS x ROWS character buffer with logical-to-physical row mapping, a clear/scroll fill engine and 1-cycle reads.
// Optional hardware scroll (top_row register, row-offset adders) is built only when TEXT_BUFFER_SCROLL_EN is defined.
module text_buffer #(
  parameter int COLS = 80,
  parameter int ROWS = 32,
  parameter int DW = 8,
  parameter logic [DW-1:0] FILL = DW'(8'h20)
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      wr_en,
  input  logic [$clog2(COLS)-1:0]   wr_col,
  input  logic [$clog2(ROWS)-1:0]   wr_row,
  input  logic [DW-1:0]             wr_data,
  output logic                      wr_ready,
  input  logic                      rd_en,
  input  logic [$clog2(COLS)-1:0]   rd_col,
  input  logic [$clog2(ROWS)-1:0]   rd_row,
  output logic [DW-1:0]             rd_data,
  input  logic                      clear_req,
  input  logic                      scroll_req,
  output logic                      busy,
  output logic [$clog2(ROWS)-1:0]   top_row
);

  localparam int CW    = $clog2(COLS);
  localparam int RW    = $clog2(ROWS);
  localparam int DEPTH = COLS * ROWS;
  localparam int AW    = $clog2(DEPTH);

`ifdef TEXT_BUFFER_SCROLL_EN
  typedef enum logic [1:0] {IDLE, CLEAR, SCROLL} state_t;
`else
  typedef enum logic {IDLE, CLEAR} state_t;
`endif

  state_t          state, state_nxt;
  logic [AW-1:0]   fcnt, fcnt_nxt;
  logic            busy_q;
  logic            fill_we;
  logic [AW-1:0]   fill_addr;
  logic [DW-1:0]   mem [DEPTH];

`ifdef TEXT_BUFFER_SCROLL_EN
  logic [RW-1:0]   top_q, top_nxt;
  logic [RW-1:0]   fill_row;
`endif

  // Logical (row, col) to flat physical address; row is assumed already range-checked.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] row, input logic [CW-1:0] col);
    logic [RW-1:0] prow;
`ifdef TEXT_BUFFER_SCROLL_EN
    logic [RW:0]   sum;
    sum = {1'b0, row} + {1'b0, top_q};
    if (sum >= (RW+1)'(ROWS)) sum = sum - (RW+1)'(ROWS);
    prow = sum[RW-1:0];
`else
    prow = row;
`endif
    return AW'(prow) * AW'(COLS) + AW'(col);
  endfunction

  logic          wr_in_range, rd_in_range, wr_ok;
  logic [AW-1:0] wr_addr, rd_addr;

  assign wr_in_range = ({1'b0, wr_col} < (CW+1)'(COLS)) && ({1'b0, wr_row} < (RW+1)'(ROWS));
  assign rd_in_range = ({1'b0, rd_col} < (CW+1)'(COLS)) && ({1'b0, rd_row} < (RW+1)'(ROWS));
  assign wr_ok       = wr_en && !busy_q && wr_in_range;
  assign wr_addr     = cell_addr(wr_row, wr_col);
  assign rd_addr     = cell_addr(rd_row, rd_col);

  assign busy     = busy_q;
  assign wr_ready = ~busy_q;

`ifdef TEXT_BUFFER_SCROLL_EN
  assign top_row  = top_q;
  // After the pointer advances, the row just scrolled off the top becomes the new bottom row.
  assign fill_row = (top_q == '0) ? RW'(ROWS - 1) : top_q - RW'(1);
`else
  logic unused_scroll;
  assign unused_scroll = scroll_req;
  assign top_row = '0;
`endif

  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    fill_we   = 1'b0;
    fill_addr = '0;
`ifdef TEXT_BUFFER_SCROLL_EN
    top_nxt   = top_q;
`endif
    case (state)
      IDLE: begin
        if (clear_req) begin
          fcnt_nxt  = '0;
          state_nxt = CLEAR;
`ifdef TEXT_BUFFER_SCROLL_EN
          top_nxt   = '0;
        end else if (scroll_req) begin
          top_nxt   = (top_q == RW'(ROWS - 1)) ? '0 : top_q + RW'(1);
          fcnt_nxt  = '0;
          state_nxt = SCROLL;
`endif
        end
      end
      CLEAR: begin
        fill_we   = 1'b1;
        fill_addr = fcnt;
        fcnt_nxt  = fcnt + AW'(1);
        if (fcnt == AW'(DEPTH - 1)) state_nxt = IDLE;
      end
`ifdef TEXT_BUFFER_SCROLL_EN
      SCROLL: begin
        fill_we   = 1'b1;
        fill_addr = AW'(fill_row) * AW'(COLS) + fcnt;
        fcnt_nxt  = fcnt + AW'(1);
        if (fcnt == AW'(COLS - 1)) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      fcnt   <= '0;
      busy_q <= 1'b0;
`ifdef TEXT_BUFFER_SCROLL_EN
      top_q  <= '0;
`endif
    end else begin
      state  <= state_nxt;
      fcnt   <= fcnt_nxt;
      busy_q <= (state_nxt != IDLE);
`ifdef TEXT_BUFFER_SCROLL_EN
      top_q  <= top_nxt;
`endif
    end
  end

  // Fill and terminal writes are mutually exclusive: writes need ~busy, fills only run while busy.
  always_ff @(posedge clk) begin
    if (resetn) begin
      if (fill_we) mem[fill_addr] <= FILL;
      else if (wr_ok) mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) rd_data <= '0;
    else if (rd_en) rd_data <= rd_in_range ? mem[rd_addr] : FILL;
  end

endmodule

// File: tb/tb_text_buffer.sv
// Scoreboard bench for text_buffer: a cell-array reference model predicts reads, busy and top_row.
// Scroll tests run only when TEXT_BUFFER_SCROLL_EN is defined; otherwise scroll_req must be ignored.
module tb_text_buffer;
  localparam int COLS = 80, ROWS = 32, DW = 8, CW = 7, RW = 5, DEPTH = COLS * ROWS;
  localparam logic [7:0] FILL = 8'h20;

  logic clk, resetn, wr_en, rd_en, clear_req, scroll_req;
  logic [CW-1:0] wr_col, rd_col;
  logic [RW-1:0] wr_row, rd_row, top_row;
  logic [DW-1:0] wr_data, rd_data;
  logic wr_ready, busy;

  text_buffer #(.COLS(COLS), .ROWS(ROWS), .DW(DW), .FILL(FILL)) dut (
    .clk(clk), .resetn(resetn), .wr_en(wr_en), .wr_col(wr_col), .wr_row(wr_row),
    .wr_data(wr_data), .wr_ready(wr_ready), .rd_en(rd_en), .rd_col(rd_col), .rd_row(rd_row),
    .rd_data(rd_data), .clear_req(clear_req), .scroll_req(scroll_req), .busy(busy), .top_row(top_row)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {logic [7:0] val; bit care;} exp_t;
  exp_t sb[$];
  int checks = 0, errors = 0;

  int top_m = 0, busy_cnt = 0, fill_prow = 0;
  bit fill_clear = 1'b0;
  logic [7:0] mem_m [ROWS][COLS];
  bit known_m [ROWS][COLS];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: advances by one clock edge using the inputs currently driven.
  function automatic void model_step();
    int p;
    exp_t e;
    if (!resetn) begin
      if (busy_cnt > 0) begin
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++)
            if (fill_clear || r == fill_prow) known_m[r][c] = 1'b0;
      end
      busy_cnt = 0;
      top_m = 0;
      return;
    end
    if (rd_en) begin
      if (int'(rd_col) >= COLS || int'(rd_row) >= ROWS) begin
        e.val = FILL; e.care = 1'b1;
      end else begin
        p = (int'(rd_row) + top_m) % ROWS;
        e.val = mem_m[p][rd_col]; e.care = known_m[p][rd_col];
      end
      sb.push_back(e);
    end
    if (busy_cnt > 0) begin
      busy_cnt--;
      return;
    end
    if (wr_en && int'(wr_col) < COLS && int'(wr_row) < ROWS) begin
      p = (int'(wr_row) + top_m) % ROWS;
      mem_m[p][wr_col] = wr_data;
      known_m[p][wr_col] = 1'b1;
    end
    if (clear_req) begin
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++) begin
          mem_m[r][c] = FILL; known_m[r][c] = 1'b1;
        end
      top_m = 0; busy_cnt = DEPTH; fill_clear = 1'b1;
    end
`ifdef TEXT_BUFFER_SCROLL_EN
    else if (scroll_req) begin
      top_m = (top_m + 1) % ROWS;
      fill_prow = (top_m + ROWS - 1) % ROWS;
      for (int c = 0; c < COLS; c++) begin
        mem_m[fill_prow][c] = FILL; known_m[fill_prow][c] = 1'b1;
      end
      busy_cnt = COLS; fill_clear = 1'b0;
    end
`endif
  endfunction

  // Monitor: pops the scoreboard whenever a read was issued, and tracks status outputs every cycle.
  logic mon_rd;
  always @(posedge clk) begin
    mon_rd = rd_en && resetn;
    #1;
    if (mon_rd) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        exp_t e;
        e = sb.pop_front();
        if (e.care) chk("rd_data", rd_data, e.val);
      end
    end
    chk("busy", busy, busy_cnt > 0);
    chk("wr_ready", wr_ready, busy_cnt == 0);
    chk("top_row", top_row, top_m);
  end

  task automatic cycle();
    model_step();
    @(negedge clk);
    wr_en = 0; rd_en = 0; clear_req = 0; scroll_req = 0;
  endtask

  task automatic rd(input int c, input int r);
    rd_en = 1; rd_col = CW'(c); rd_row = RW'(r);
    cycle();
  endtask

  task automatic wr(input int c, input int r, input logic [7:0] d);
    wr_en = 1; wr_col = CW'(c); wr_row = RW'(r); wr_data = d;
    cycle();
  endtask

  // Called right after the accepting edge; counts busy cycles up to a bound.
  task automatic wait_idle(input string name, input int expected);
    int n = 0;
    while (busy === 1'b1 && n < expected + 50) begin
      n++;
      cycle();
    end
    chk(name, n, expected);
  endtask

  initial begin
    resetn = 0; wr_en = 0; rd_en = 0; clear_req = 0; scroll_req = 0;
    wr_col = '0; wr_row = '0; wr_data = '0; rd_col = '0; rd_row = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        known_m[r][c] = 1'b0; mem_m[r][c] = '0;
      end
    @(negedge clk);
    repeat (3) cycle();
    chk("reset_rd_data", rd_data, 0);
    chk("reset_busy", busy, 0);
    resetn = 1;
    cycle();

    // Clear whole buffer.
    clear_req = 1; cycle();
    wait_idle("clear_busy_cycles", DEPTH);
    chk("clear_top_row", top_row, 0);
    rd(0, 0); rd(COLS - 1, ROWS - 1); cycle();

    // Basic write/read, read-first, out-of-range write.
    wr(5, 3, 8'h41); rd(5, 3);
    wr_en = 1; wr_col = 6; wr_row = 3; wr_data = 8'h42; rd_en = 1; rd_col = 6; rd_row = 3; cycle();
    rd(6, 3);
    wr(COLS, 3, 8'h55); rd(0, 4); rd(COLS - 1, 3); rd(COLS, 3);
    wr(COLS + 5, 0, 8'h56); rd(0, 1); cycle();

`ifdef TEXT_BUFFER_SCROLL_EN
    wr(0, 1, 8'h41);
    scroll_req = 1; cycle();
    wait_idle("scroll_busy_cycles", COLS);
    chk("scroll_top_row", top_row, 1);
    rd(0, 0);
    for (int c = 0; c < COLS; c++) rd(c, ROWS - 1);
    for (int i = 0; i < ROWS - 1; i++) begin
      scroll_req = 1; cycle();
      wait_idle("scroll_n_busy", COLS);
    end
    chk("scroll_wrap_top_row", top_row, 0);
    scroll_req = 1; cycle();
    wait_idle("scroll_pre_busy", COLS);
`else
    scroll_req = 1; cycle();
    chk("scroll_ignored_busy", busy, 0);
    chk("scroll_ignored_top", top_row, 0);
`endif

    // Clear and scroll together: clear wins; then requests/writes while busy are dropped.
    clear_req = 1; scroll_req = 1; cycle();
    chk("clear_wins_wr_ready", wr_ready, 0);
    for (int i = 0; i < 200; i++) begin
      wr_en = 1; wr_col = CW'($urandom_range(0, COLS - 1)); wr_row = RW'($urandom_range(0, ROWS - 1));
      wr_data = 8'($urandom); scroll_req = (i % 7 == 0); clear_req = (i % 11 == 0);
      cycle();
    end
    wait_idle("clear_wins_busy", DEPTH - 200);
    chk("clear_wins_top_row", top_row, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) rd(c, r);
    cycle();

    // Reset in the middle of a clear.
    clear_req = 1; cycle();
    repeat (1000) cycle();
    resetn = 0; cycle();
    chk("abort_busy", busy, 0);
    chk("abort_top_row", top_row, 0);
    chk("abort_rd_data", rd_data, 0);
    resetn = 1;
    wr(2, 2, 8'h77); rd(2, 2); rd(3, 3); cycle();
    clear_req = 1; cycle();
    wait_idle("reclear_busy", DEPTH);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      wr_en = 1'($urandom_range(0, 1));
      wr_col = CW'($urandom_range(0, COLS + 5)); wr_row = RW'($urandom_range(0, ROWS - 1));
      wr_data = 8'($urandom);
      if (busy_cnt == 0) begin
        rd_en = 1'($urandom_range(0, 1));
        rd_col = CW'($urandom_range(0, COLS + 5)); rd_row = RW'($urandom_range(0, ROWS - 1));
      end
      scroll_req = ($urandom_range(0, 29) == 0);
      clear_req = (busy_cnt > 0) && ($urandom_range(0, 9) == 0);
      cycle();
    end
    repeat (3) cycle();
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
